// File: rtl/spi_slave.sv
// SPI target endpoint: oversamples sclk/ss_n/mosi in the clk domain and supports all
// four CPOL/CPHA modes. It shifts DATA_WIDTH-bit words MSB-first in both directions.
module spi_slave #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q, fill_q;
    logic                   sclk_dly_q, ss_dly_q, armed_q, lead_q, trail_q;
    logic                   sclk_s, ss_s, mosi_s, sclk_chg, ss_fall, ss_rise;
    logic                   sample_edge, shift_edge, done;

    state_e                 state_q, state_d;
    logic                   cpol_q, cpol_d, cpha_q, cpha_d;
    logic [DATA_WIDTH-1:0]  tx_hold_q, tx_hold_d, tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_chg = sclk_s ^ sclk_dly_q;
    // A falling ss_n only counts once ss_n has been seen high with real (post-reset) data.
    assign ss_fall  = armed_q & ss_dly_q & ~ss_s;
    assign ss_rise  = ~ss_dly_q & ss_s;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b1;
            armed_q     <= 1'b0;
            lead_q      <= 1'b0;
            trail_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_dly_q  <= sclk_s;
            ss_dly_q    <= ss_s;
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & ss_s);
            lead_q      <= sclk_chg & (sclk_dly_q == cpol_q);
            trail_q     <= sclk_chg & (sclk_s == cpol_q);
        end
    end

    assign sample_edge = cpha_q ? trail_q : lead_q;
    assign shift_edge  = cpha_q ? lead_q : trail_q;
    assign done        = (bit_cnt_q == CW'(DATA_WIDTH));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        tx_hold_d   = tx_load ? tx_data : tx_hold_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    tx_shift_d = tx_load ? tx_data : tx_hold_q;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sample_edge && !done) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                    end
                end
                // In cpha=1 the first leading edge only presents the MSB.
                if (shift_edge && !done && (!cpha_q || bit_cnt_q != '0)) begin
                    tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                end
                if (ss_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_d != CW'(DATA_WIDTH));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            tx_hold_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            tx_hold_q   <= tx_hold_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = (state_q == ACTIVE) & tx_shift_q[DATA_WIDTH-1];
    assign miso_oe   = (state_q == ACTIVE);
    assign busy      = (state_q == ACTIVE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a behavioural SPI master drives frames, and a monitor
// checks every rx_valid against the queue of words that the master sent.
module tb_spi_slave;
    localparam int DW = 16;
    localparam int H  = 6;   // sclk half-period in clk cycles

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpol = 1'b0, cpha = 1'b0, tx_load = 1'b0;
    logic          sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          miso, miso_oe, busy, rx_valid, frame_err;
    logic [DW-1:0] rx_data;

    int            checks = 0, errors = 0, rv_cnt = 0, fe_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [31:0]   mrx;
    int            rv0, fe0;

    always #5 clk = ~clk;

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_load(tx_load), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .busy(busy), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: consumes expected words whenever the DUT presents rx_valid.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid) begin
                rv_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_valid_unexpected: got rx_data %0h expected no word", rx_data);
                end else begin
                    check("rx_data_sb", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err) fe_cnt++;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic load_tx(input logic [DW-1:0] w);
        @(negedge clk);
        tx_data = w;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic frame(input logic m_cpol, input logic m_cpha, input logic [DW-1:0] mtx,
                         input int nclk, input bit load_fall, input logic [DW-1:0] load_word,
                         input bit keep_low, output logic [31:0] rx);
        logic b;
        rx = '0;
        @(negedge clk);
        cpol = m_cpol;
        cpha = m_cpha;
        sclk = m_cpol;
        mosi = 1'b0;
        wait_clk(H);
        ss_n = 1'b0;
        if (load_fall) begin
            wait_clk(2);  // lands tx_load on the cycle the synced ss_n fall is decided
            tx_data = load_word;
            tx_load = 1'b1;
            wait_clk(1);
            tx_load = 1'b0;
        end
        wait_clk(H);
        for (int i = 0; i < nclk; i++) begin
            b = (i < DW) ? mtx[DW-1-i] : 1'b0;
            if (!m_cpha) begin
                mosi = b;
                wait_clk(H);
                sclk = ~m_cpol;
                rx = {rx[30:0], miso};
                wait_clk(H);
                sclk = m_cpol;
            end else begin
                sclk = ~m_cpol;
                mosi = b;
                wait_clk(H);
                sclk = m_cpol;
                rx = {rx[30:0], miso};
                wait_clk(H);
            end
        end
        wait_clk(H);
        if (!keep_low) begin
            ss_n = 1'b1;
            wait_clk(4 * H);
        end
    endtask

    task automatic post_frame(input string tag, input int exp_rv, input int exp_fe);
        check({tag, "_rx_valid_count"}, 32'(rv_cnt - rv0), 32'(exp_rv));
        check({tag, "_frame_err_count"}, 32'(fe_cnt - fe0), 32'(exp_fe));
        check({tag, "_miso_oe_idle"}, 32'(miso_oe), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"}, 32'(miso), 32'd0);
        check({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        wait_clk(3);
        check_reset_values("reset");
        reset_n = 1'b1;
        wait_clk(5);

        // Mode 0 single frame
        load_tx(16'hA55A);
        exp_q.push_back(16'h3C96);
        rv0 = rv_cnt; fe0 = fe_cnt;
        frame(1'b0, 1'b0, 16'h3C96, 16, 1'b0, '0, 1'b0, mrx);
        check("mode0_master_rx", mrx & 32'hFFFF, 32'hA55A);
        post_frame("mode0", 1, 0);

        // All four modes back to back
        for (int m = 0; m < 4; m++) begin
            logic [DW-1:0] stx, mtx;
            logic [1:0]    md;
            md  = 2'(m);
            stx = md[0] ? 16'h7FFE : 16'h8001;
            mtx = md[0] ? 16'h0FF0 : 16'hF00F;
            load_tx(stx);
            exp_q.push_back(mtx);
            rv0 = rv_cnt; fe0 = fe_cnt;
            frame(md[1], md[0], mtx, 16, 1'b0, '0, 1'b0, mrx);
            check($sformatf("mode%0d_master_rx", m), mrx & 32'hFFFF, 32'(stx));
            post_frame($sformatf("mode%0d", m), 1, 0);
        end

        // Short frame: ss_n released after 7 sample edges
        rv0 = rv_cnt; fe0 = fe_cnt;
        frame(1'b0, 1'b0, 16'hFFFF, 7, 1'b0, '0, 1'b0, mrx);
        post_frame("short", 0, 1);
        check("short_rx_data_held", 32'(rx_data), 32'h0FF0);

        load_tx(16'h6789);
        exp_q.push_back(16'h1234);
        rv0 = rv_cnt; fe0 = fe_cnt;
        frame(1'b0, 1'b0, 16'h1234, 16, 1'b0, '0, 1'b0, mrx);
        check("after_short_master_rx", mrx & 32'hFFFF, 32'h6789);
        post_frame("after_short", 1, 0);

        // Reset mid-frame after 5 bits, ss_n kept low
        frame(1'b0, 1'b0, 16'hABCD, 5, 1'b0, '0, 1'b1, mrx);
        @(negedge clk);
        reset_n = 1'b0;
        wait_clk(2);
        check_reset_values("midreset");
        reset_n = 1'b1;
        wait_clk(2 * H);
        rv0 = rv_cnt; fe0 = fe_cnt;
        for (int i = 0; i < 16; i++) begin
            mosi = 1'(i);
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
            wait_clk(H);
        end
        wait_clk(2 * H);
        check("held_low_busy", 32'(busy), 32'd0);
        check("held_low_miso_oe", 32'(miso_oe), 32'd0);
        check("held_low_rx_valid_count", 32'(rv_cnt - rv0), 32'd0);
        ss_n = 1'b1;
        wait_clk(2 * H);
        exp_q.push_back(16'hCAFE);
        rv0 = rv_cnt; fe0 = fe_cnt;
        frame(1'b0, 1'b0, 16'hCAFE, 16, 1'b0, '0, 1'b0, mrx);
        check("post_reset_master_rx", mrx & 32'hFFFF, 32'h0000);
        post_frame("post_reset", 1, 0);

        // tx_load on the same cycle as the synced ss_n fall (tx_hold still zero)
        exp_q.push_back(16'h2468);
        rv0 = rv_cnt; fe0 = fe_cnt;
        frame(1'b0, 1'b1, 16'h2468, 16, 1'b1, 16'hBEEF, 1'b0, mrx);
        check("load_at_fall_master_rx", mrx & 32'hFFFF, 32'hBEEF);
        post_frame("load_at_fall", 1, 0);

        // 20 sclk cycles for a 16-bit frame
        load_tx(16'h1357);
        exp_q.push_back(16'h00FF);
        rv0 = rv_cnt; fe0 = fe_cnt;
        frame(1'b0, 1'b0, 16'h00FF, 20, 1'b0, '0, 1'b0, mrx);
        check("overrun_master_rx", (mrx >> 4) & 32'hFFFF, 32'h1357);
        post_frame("overrun", 1, 0);
        check("overrun_rx_data", 32'(rx_data), 32'h00FF);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (slave) endpoint; the far end of the team's spi_master.
- Oversamples sclk, ss_n and mosi in the system clock domain and supports all four CPOL/CPHA modes.
- Shifts DATA_WIDTH-bit words MSB-first in both directions. Presents each received word with a one-cycle valid strobe and returns a preloaded transmit word on miso.

Parameters:
- DATA_WIDTH, 16, frame length in bits (≥2)
- SYNC_STAGES, 2, synchronizer depth on sclk/ss_n/mosi (≥2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpol  in  1  idle sclk level; captured at frame start
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; captured at frame start
- tx_data  in  DATA_WIDTH  word to return on the next frame
- tx_load  in  1  writes tx_data into the tx holding register
- sclk  in  1  SPI clock from master (asynchronous)
- ss_n  in  1  active-low select (asynchronous)
- mosi  in  1  master-out data (asynchronous)
- miso  out  1  slave-out data
- miso_oe  out  1  miso output enable (high only while selected)
- busy  out  1  frame in progress
- rx_data  out  DATA_WIDTH  last complete received word
- rx_valid  out  1  one-cycle pulse: rx_data updated
- frame_err  out  1  one-cycle pulse: ss_n released before DATA_WIDTH bits

Behaviour:
- Reset: miso=0, miso_oe=0, busy=0, rx_data=0, rx_valid=0, frame_err=0, tx_hold=0, state=IDLE. Sync flops reset to ss_n=1, sclk=0, mosi=0.
- Synchronization: sclk, ss_n and mosi each pass through SYNC_STAGES flops. Edges are detected by comparing the sync output with one further delay flop.
- Leading edge: synced sclk leaves the cpol level. Trailing edge: it returns to the cpol level.
- Sample edge = leading if cpha=0, else trailing. Shift edge = the other one.
- Timing requirement: each sclk half-period must be ≥ SYNC_STAGES+2 clk cycles; behaviour is undefined below this. With the team's master and SYNC_STAGES=2, clk_div ≥ 3.
- tx_load: accepted in any cycle. tx_hold <= tx_data.
- States: IDLE, ACTIVE.
- IDLE:
  - miso_oe=0, miso=0.
  - On synced ss_n falling: capture cpol/cpha, load tx_shift from tx_hold, clear bit_cnt, busy=1, miso_oe=1, enter ACTIVE.
  - If tx_load occurs in the same cycle as the ss_n fall, the new tx_data is loaded.
- ACTIVE, miso driving:
  - miso = tx_shift[DATA_WIDTH-1].
  - cpha=0: MSB is valid from entry; tx_shift shifts left on each shift (trailing) edge.
  - cpha=1: the first leading edge does not shift, so the MSB is presented for the first sample; each subsequent leading edge shifts left.
  - Zeros fill from the LSB.
- ACTIVE, receiving:
  - On each sample edge while bit_cnt < DATA_WIDTH: rx_shift <= {rx_shift[DATA_WIDTH-2:0], synced mosi}; bit_cnt++.
  - On the sample edge that completes the DATA_WIDTH-th bit, in the same registered update: rx_data <= completed word, rx_valid=1 for exactly one cycle.
  - Latency: rx_valid rises SYNC_STAGES+1 clk cycles after the clk edge that first captures the raw sclk transition.
- ACTIVE, after DATA_WIDTH bits: further sclk edges are ignored, miso holds its last value, and the word is not re-captured.
- ACTIVE, on synced ss_n rising: busy=0, miso_oe=0, miso=0, return to IDLE.
  - If bit_cnt < DATA_WIDTH: frame_err pulses one cycle and rx_data is unchanged.
  - ss_n rising in the same cycle as the final sample edge: the sample completes first (rx_valid=1, frame_err=0).
- rx_data holds its value until the next complete frame. There is no back-pressure; the consumer must take rx_data before the next frame completes.
- Asynchronous reset mid-frame: immediate return to reset values. A new frame requires a synced ss_n falling edge, so a low ss_n held through reset release does not start a frame.

Test Plan:
- Mode 0 (cpol=0, cpha=0), DATA_WIDTH=16, spi_master clk_div=3. tx_load 16'hA55A; master sends 16'h3C96. Expected: rx_valid once, rx_data=16'h3C96, master rx_data=16'hA55A.
- All four modes back-to-back. tx 16'h8001 then 16'h7FFE; master sends 16'hF00F then 16'h0FF0. Expected: each frame gives a matching rx_data and a single rx_valid; miso_oe low between frames.
- ss_n released after 7 sample edges. Expected: frame_err one pulse, no rx_valid, rx_data keeps its prior value. The next full frame (16'h1234) is received correctly.
- tx_load 16'hBEEF in the same cycle as the ss_n fall (tx_hold previously 16'h0000). Expected: master receives 16'hBEEF.
- reset_n pulsed low mid-frame after 5 bits with ss_n kept low. Expected: all outputs at reset values, no rx_valid while ss_n stays low. After an ss_n high-then-low sequence, 16'hCAFE is received.
- Master sends 20 sclk cycles with DATA_WIDTH=16, word 16'h00FF. Expected: exactly one rx_valid, rx_data=16'h00FF, extra edges ignored, no frame_err on ss_n rise.
